// File: rtl/local_pattern_table.sv
// Local-path pattern table: 2-bit saturating counters indexed by local history.
// Tracks in-flight lookups in a FIFO so in-order resolutions train the counter that predicted.
module local_pattern_table #(
   parameter int         HIST_W      = 10,
   parameter int         QUEUE_DEPTH = 4,
   parameter logic [1:0] INIT_CTR    = 2'b01
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         lookup_valid,
   input  logic [HIST_W-1:0]            lookup_history,
   output logic                         lookup_ready,
   output logic                         pred_valid,
   output logic                         pred_taken,
   output logic [1:0]                   pred_ctr,
   input  logic                         resolve_valid,
   input  logic                         resolve_taken,
   output logic [$clog2(QUEUE_DEPTH):0] queue_count,
   output logic                         init_done,
   output logic                         resolve_err
);

   localparam int            TBL  = 1 << HIST_W;
   localparam int            PW   = $clog2(QUEUE_DEPTH);
   localparam logic [PW:0]   FULL = (PW+1)'(QUEUE_DEPTH);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t              state_q, state_d;
   logic [HIST_W-1:0]   sweep_idx;
   logic [1:0]          ctr_tab [TBL];
   logic [HIST_W-1:0]   fifo    [QUEUE_DEPTH];
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic                in_run, push, pop, err_set;
   logic [HIST_W-1:0]   pop_hist;
   logic [1:0]          upd_ctr;

   function automatic logic [1:0] sat_upd(input logic [1:0] c, input logic t);
      if (t) return (c == 2'b11) ? c : c + 2'b01;
      else   return (c == 2'b00) ? c : c - 2'b01;
   endfunction

   always_comb begin
      state_d = state_q;
      if (state_q == S_INIT && sweep_idx == HIST_W'(TBL - 1)) state_d = S_RUN;
   end

   // Ready depends only on registered state; resolve never feeds it combinationally.
   assign lookup_ready = init_done && (queue_count < FULL);
   assign in_run       = (state_q == S_RUN);
   assign push         = lookup_valid && lookup_ready;
   assign pop          = in_run && resolve_valid && (queue_count != '0);
   assign err_set      = in_run && resolve_valid && (queue_count == '0);
   assign pop_hist     = fifo[rd_ptr];
   assign upd_ctr      = sat_upd(ctr_tab[pop_hist], resolve_taken);
   assign pred_taken   = pred_ctr[1];

   // Storage is not reset; the sweep writes every entry before RUN.
   always_ff @(posedge clock) begin
      if (state_q == S_INIT) ctr_tab[sweep_idx] <= INIT_CTR;
      else if (pop)          ctr_tab[pop_hist]  <= upd_ctr;
      if (push) fifo[wr_ptr] <= lookup_history;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_INIT;
         sweep_idx   <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         queue_count <= '0;
         pred_valid  <= 1'b0;
         pred_ctr    <= 2'b00;
         init_done   <= 1'b0;
         resolve_err <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_done  <= (state_d == S_RUN);
         pred_valid <= push;
         if (state_q == S_INIT) sweep_idx <= sweep_idx + HIST_W'(1);
         // Read-before-write: same-cycle update to this index is not bypassed.
         if (push) begin
            pred_ctr <= ctr_tab[lookup_history];
            wr_ptr   <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   queue_count <= queue_count + (PW+1)'(1);
            2'b01:   queue_count <= queue_count - (PW+1)'(1);
            default: queue_count <= queue_count;
         endcase
         if (err_set) resolve_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_local_pattern_table.sv
// Bench for local_pattern_table: array/queue reference model checked every cycle plus directed literals.
module tb_local_pattern_table;
   localparam int HW = 10;
   localparam int QD = 4;

   logic          clock = 0, reset = 0;
   logic          lookup_valid = 0, resolve_valid = 0, resolve_taken = 0;
   logic [HW-1:0] lookup_history = '0;
   logic          lookup_ready, pred_valid, pred_taken, init_done, resolve_err;
   logic [1:0]    pred_ctr;
   logic [2:0]    queue_count;

   local_pattern_table #(.HIST_W(HW), .QUEUE_DEPTH(QD), .INIT_CTR(2'b01)) dut (
      .clock(clock), .reset(reset),
      .lookup_valid(lookup_valid), .lookup_history(lookup_history), .lookup_ready(lookup_ready),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ctr(pred_ctr),
      .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
      .queue_count(queue_count), .init_done(init_done), .resolve_err(resolve_err)
   );

   always #5 clock = ~clock;

   int checks = 0, errors = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: table of ints, queue of in-flight histories, cycle counter for the sweep.
   int  m_tab [1 << HW];
   int  q [$];
   int  m_idx, m_pc, m_rd, m_h;
   bit  m_done, m_pv, m_err, m_acc;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_idx = 0; m_done = 0; m_pv = 0; m_pc = 0; m_err = 0;
         q.delete();
      end else if (!m_done) begin
         m_tab[m_idx] = 1;
         m_idx++;
         if (m_idx == (1 << HW)) m_done = 1;
         m_pv = 0;
      end else begin
         m_acc = lookup_valid && (q.size() < QD);
         m_rd  = m_tab[lookup_history];
         if (resolve_valid) begin
            if (q.size() > 0) begin
               m_h = q.pop_front();
               if (resolve_taken) m_tab[m_h] = (m_tab[m_h] == 3) ? 3 : m_tab[m_h] + 1;
               else               m_tab[m_h] = (m_tab[m_h] == 0) ? 0 : m_tab[m_h] - 1;
            end else m_err = 1;
         end
         if (m_acc) begin
            q.push_back(int'(lookup_history));
            m_pc = m_rd;
         end
         m_pv = m_acc;
      end
   end

   always @(negedge clock) begin
      cmp("init_done", init_done, m_done);
      cmp("lookup_ready", lookup_ready, m_done && (q.size() < QD));
      cmp("queue_count", queue_count, q.size());
      cmp("resolve_err", resolve_err, m_err);
      cmp("pred_valid", pred_valid, m_pv);
      if (m_pv) begin
         cmp("pred_ctr", pred_ctr, m_pc);
         cmp("pred_taken", pred_taken, m_pc >> 1);
      end
   end

   task automatic drive(input logic lv, input logic [HW-1:0] lh, input logic rv, input logic rt);
      lookup_valid = lv; lookup_history = lh; resolve_valid = rv; resolve_taken = rt;
      @(posedge clock); #1;
      lookup_valid = 0; resolve_valid = 0; resolve_taken = 0;
   endtask

   task automatic wait_init(output int n);
      n = 0;
      while (!init_done && n < 1100) begin
         @(posedge clock); #1;
         n++;
      end
   endtask

   int n;
   int exp3 [3]  = '{1, 2, 3};
   int exp5 [5]  = '{3, 2, 1, 0, 0};

   initial begin
      repeat (3) @(posedge clock);
      #1;
      cmp("lit_rst_init_done", init_done, 0);
      cmp("lit_rst_resolve_err", resolve_err, 0);
      cmp("lit_rst_pred_valid", pred_valid, 0);
      cmp("lit_rst_pred_ctr", pred_ctr, 0);
      cmp("lit_rst_pred_taken", pred_taken, 0);
      cmp("lit_rst_queue_count", queue_count, 0);

      // Sweep with lookup and resolve held high: both must be ignored.
      @(negedge clock);
      reset = 1;
      lookup_valid = 1; lookup_history = 10'h3FF; resolve_valid = 1; resolve_taken = 1;
      wait_init(n);
      lookup_valid = 0; resolve_valid = 0; resolve_taken = 0;
      cmp("lit_init_cycles", n, 1024);
      cmp("lit_init_no_err", resolve_err, 0);
      cmp("lit_init_queue_empty", queue_count, 0);

      drive(1, 10'h3FF, 0, 0);
      cmp("lit_3ff_valid", pred_valid, 1);
      cmp("lit_3ff_ctr", pred_ctr, 1);
      cmp("lit_3ff_taken", pred_taken, 0);
      drive(0, 0, 1, 0);

      // Training 0x155 up to saturation and back down.
      drive(1, 10'h155, 0, 0);
      cmp("lit_155_first", pred_ctr, 1);
      for (int i = 0; i < 3; i++) begin
         drive(1, 10'h155, 1, 1);
         cmp($sformatf("lit_155_up%0d", i), pred_ctr, exp3[i]);
      end
      drive(0, 0, 1, 1);
      drive(1, 10'h155, 0, 0);
      cmp("lit_155_sat", pred_ctr, exp5[0]);
      for (int i = 1; i < 5; i++) begin
         drive(1, 10'h155, 1, 0);
         cmp($sformatf("lit_155_dn%0d", i), pred_ctr, exp5[i-1]);
      end
      drive(1, 10'h155, 0, 0);
      cmp("lit_155_floor", pred_ctr, 0);
      drive(0, 0, 1, 0);
      drive(0, 0, 1, 0);

      // Full queue back-pressure.
      for (int i = 0; i < 4; i++) drive(1, HW'(16 + i), 0, 0);
      cmp("lit_full_count", queue_count, 4);
      cmp("lit_full_ready", lookup_ready, 0);
      drive(1, 10'h014, 0, 0);
      cmp("lit_full_no_pred", pred_valid, 0);
      cmp("lit_full_count_hold", queue_count, 4);
      drive(0, 0, 1, 1);
      cmp("lit_after_pop_count", queue_count, 3);
      cmp("lit_after_pop_ready", lookup_ready, 1);
      repeat (3) drive(0, 0, 1, 1);

      // Simultaneous push/pop at count 2 across pointer wrap; odd histories trained taken.
      drive(1, 10'h001, 0, 0);
      drive(1, 10'h002, 0, 0);
      for (int k = 3; k <= 12; k++) begin
         drive(1, HW'(k), 1, logic'((k - 2) & 1));
         cmp($sformatf("lit_pushpop_count%0d", k), queue_count, 2);
      end
      drive(0, 0, 1, 1);
      drive(0, 0, 1, 0);
      for (int k = 1; k <= 12; k++) begin
         drive(1, HW'(k), 0, 0);
         cmp($sformatf("lit_fifo_order%0d", k), pred_ctr, (k & 1) ? 2 : 0);
         drive(0, 0, 1, 1);
      end

      // Same-cycle lookup and update of 0x0AA: read-before-write.
      drive(1, 10'h0AA, 0, 0);
      cmp("lit_aa_first", pred_ctr, 1);
      drive(1, 10'h0AA, 1, 1);
      cmp("lit_aa_same_cycle", pred_ctr, 1);
      drive(1, 10'h0AA, 0, 0);
      cmp("lit_aa_after", pred_ctr, 2);
      drive(0, 0, 1, 0);
      drive(0, 0, 1, 0);

      // Resolve on empty queue sets a sticky error.
      drive(0, 0, 1, 1);
      cmp("lit_err_set", resolve_err, 1);
      drive(1, 10'h005, 0, 0);
      drive(0, 0, 1, 0);
      cmp("lit_err_sticky", resolve_err, 1);

      // Reset mid-operation, then again mid-sweep.
      reset = 0; #1;
      cmp("lit_rst2_init_done", init_done, 0);
      cmp("lit_rst2_resolve_err", resolve_err, 0);
      @(negedge clock);
      reset = 1;
      repeat (500) @(posedge clock);
      #1;
      cmp("lit_midsweep_not_done", init_done, 0);
      reset = 0; #1;
      cmp("lit_rst3_init_done", init_done, 0);
      cmp("lit_rst3_queue_count", queue_count, 0);
      @(negedge clock);
      reset = 1;
      wait_init(n);
      cmp("lit_resweep_cycles", n, 1024);
      drive(1, 10'h155, 0, 0);
      cmp("lit_resweep_155", pred_ctr, 1);
      drive(0, 0, 1, 1);
      repeat (2) @(posedge clock);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
